hc4_mem_arbiter: RTL and testbench

// - Shares the single HC4 data-memory port between the CPU load/store path and the debug/loader port.
// - The CPU side receives the 8-bit address already resolved by the address mux ([AB] or zero-extended register).
// - Sequences each access with a fixed wait-state count, then returns a one-cycle ack with read data.
// - Sits between the CPU core or debug bridge and the data RAM; it is the only driver of the RAM port.

---
 rtl/hc4_mem_arbiter_if.sv | 41 ++++
 rtl/hc4_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_hc4_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hc4_mem_arbiter_if.sv
// Bundle of the CPU, debug and RAM-side signals of the HC4 data-memory arbiter.
// slave: the arbiter's view; master: requesters plus RAM (e.g. a testbench).
interface hc4_mem_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [3:0] cpu_wdata;
  logic       cpu_ack;
  logic [3:0] cpu_rdata;

  logic       dbg_req;
  logic       dbg_we;
  logic [7:0] dbg_addr;
  logic [3:0] dbg_wdata;
  logic       dbg_ack;
  logic [3:0] dbg_rdata;

  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/hc4_mem_arbiter.sv
// Arbitrates the HC4 data-RAM port between CPU and debug requesters with fixed wait states.
// Define HC4_ARB_ROUND_ROBIN_EN to alternate grants on ties instead of strict CPU priority.
module hc4_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  hc4_mem_arbiter_if.slave   bus,
  output logic               busy
);

  // A zero wait count behaves like one.
  localparam logic [3:0] LAST_CNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [3:0] wdata_q, wdata_d;
  logic       mem_en_q, mem_en_d;
  logic       mem_we_q, mem_we_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       dbg_ack_q, dbg_ack_d;
  logic [3:0] cpu_rdata_q, cpu_rdata_d;
  logic [3:0] dbg_rdata_q, dbg_rdata_d;
  logic       busy_q, busy_d;

  logic       grant_dbg;
  logic       sel_we;
  logic [7:0] sel_addr;
  logic [3:0] sel_wdata;

`ifdef HC4_ARB_ROUND_ROBIN_EN
  logic rr_last_dbg_q, rr_last_dbg_d;
  assign grant_dbg = bus.dbg_req & (~bus.cpu_req | ~rr_last_dbg_q);
`else
  assign grant_dbg = bus.dbg_req & ~bus.cpu_req;
`endif

  assign sel_we    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
  assign sel_addr  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign sel_wdata = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
`ifdef HC4_ARB_ROUND_ROBIN_EN
    rr_last_dbg_d = rr_last_dbg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          owner_d  = grant_dbg;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          cnt_d    = 4'd0;
          mem_en_d = 1'b1;
          mem_we_d = sel_we;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = S_ACK;
          if (owner_q) begin
            dbg_ack_d = 1'b1;
            if (!we_q) dbg_rdata_d = bus.mem_rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = bus.mem_rdata;
          end
`ifdef HC4_ARB_ROUND_ROBIN_EN
          rr_last_dbg_d = owner_q;
`endif
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 8'd0;
      wdata_q     <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= 4'd0;
      dbg_rdata_q <= 4'd0;
      busy_q      <= 1'b0;
`ifdef HC4_ARB_ROUND_ROBIN_EN
      // Pretend debug held the last grant so the first tie goes to the CPU.
      rr_last_dbg_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      busy_q      <= busy_d;
`ifdef HC4_ARB_ROUND_ROBIN_EN
      rr_last_dbg_q <= rr_last_dbg_d;
`endif
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_hc4_mem_arbiter.sv
// Self-checking bench for hc4_mem_arbiter: transaction-level timing/data model plus directed cases.
module tb_hc4_mem_arbiter;
  localparam int WC = 3;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  always #5 clk = ~clk;

  hc4_mem_arbiter_if bus();

  hc4_mem_arbiter #(.WAIT_CYCLES(WC)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  logic [3:0] ram [256];
  assign bus.mem_rdata = ram[bus.mem_addr];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [3:0] wdata;
  } txn_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model state: one access in flight at most, described by its grant cycle
  int         g_cyc;
  bit         g_dbg, g_we;
  logic [7:0] g_addr;
  logic [3:0] g_wdata, g_rd;
  bit         cpu_pend, dbg_pend, cpu_gr, dbg_gr;
  txn_t       cpu_cur, dbg_cur;
  txn_t       cpu_q[$], dbg_q[$];
  logic [3:0] exp_cpu_rd, exp_dbg_rd;
  bit         last_dbg;
  bit         nogap;
  bit         ack_log[$];
  logic [3:0] ref_mem [256];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic txn_t mk_txn(logic we, logic [7:0] addr, logic [3:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
  endfunction

  function automatic bit model_idle(int c);
    return (g_cyc < 0) || (c >= g_cyc + WC + 2);
  endfunction

  task automatic clear_model();
    g_cyc = -1;
    cpu_pend = 0; dbg_pend = 0; cpu_gr = 0; dbg_gr = 0;
    cpu_q.delete(); dbg_q.delete();
    exp_cpu_rd = 4'd0; exp_dbg_rd = 4'd0;
    last_dbg = 1'b1;
  endtask

  task automatic check_zero();
    check_eq("rst_mem_en",    32'(bus.mem_en),    0);
    check_eq("rst_mem_we",    32'(bus.mem_we),    0);
    check_eq("rst_mem_addr",  32'(bus.mem_addr),  0);
    check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check_eq("rst_busy",      32'(busy),          0);
    check_eq("rst_cpu_ack",   32'(bus.cpu_ack),   0);
    check_eq("rst_dbg_ack",   32'(bus.dbg_ack),   0);
    check_eq("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check_eq("rst_dbg_rdata", 32'(bus.dbg_rdata), 0);
  endtask

  task automatic drive_side_random_payload(bit is_dbg);
    if (is_dbg) begin
      bus.dbg_we = 1'($urandom_range(0, 1)); bus.dbg_addr = 8'($urandom_range(0, 255));
      bus.dbg_wdata = 4'($urandom_range(0, 15));
    end else begin
      bus.cpu_we = 1'($urandom_range(0, 1)); bus.cpu_addr = 8'($urandom_range(0, 255));
      bus.cpu_wdata = 4'($urandom_range(0, 15));
    end
  endtask

  // One clock: check outputs of this cycle against the model, then drive this cycle's inputs.
  task automatic step();
    bit in_acc, in_ack, win_dbg;
    txn_t t;
    @(negedge clk);
    cyc++;
    in_acc = (g_cyc >= 0) && (cyc > g_cyc) && (cyc <= g_cyc + WC);
    in_ack = (g_cyc >= 0) && (cyc == g_cyc + WC + 1);
    if (in_ack) begin
      if (!g_we) begin
        if (g_dbg) exp_dbg_rd = g_rd; else exp_cpu_rd = g_rd;
      end
      if (g_dbg) begin dbg_pend = 0; dbg_gr = 0; end
      else begin cpu_pend = 0; cpu_gr = 0; end
    end
    if (bus.cpu_ack || bus.dbg_ack) ack_log.push_back(bus.dbg_ack);

    check_eq("mem_en", 32'(bus.mem_en), 32'(in_acc));
    check_eq("mem_we", 32'(bus.mem_we), 32'(in_acc && g_we));
    if (in_acc) begin
      check_eq("mem_addr",  32'(bus.mem_addr),  32'(g_addr));
      check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(g_wdata));
    end
    check_eq("busy",      32'(busy),          32'(in_acc || in_ack));
    check_eq("cpu_ack",   32'(bus.cpu_ack),   32'(in_ack && !g_dbg));
    check_eq("dbg_ack",   32'(bus.dbg_ack),   32'(in_ack && g_dbg));
    check_eq("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_rd));
    check_eq("dbg_rdata", 32'(bus.dbg_rdata), 32'(exp_dbg_rd));

    if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;

    if (!cpu_pend && cpu_q.size() > 0 && (nogap || $urandom_range(0, 3) != 0)) begin
      cpu_cur = cpu_q.pop_front(); cpu_pend = 1;
    end
    if (!dbg_pend && dbg_q.size() > 0 && (nogap || $urandom_range(0, 3) != 0)) begin
      dbg_cur = dbg_q.pop_front(); dbg_pend = 1;
    end

    // Payload is only meaningful until granted; afterwards scramble it to prove it was latched.
    bus.cpu_req = cpu_pend;
    if (cpu_pend && !cpu_gr) begin
      bus.cpu_we = cpu_cur.we; bus.cpu_addr = cpu_cur.addr; bus.cpu_wdata = cpu_cur.wdata;
    end else drive_side_random_payload(1'b0);
    bus.dbg_req = dbg_pend;
    if (dbg_pend && !dbg_gr) begin
      bus.dbg_we = dbg_cur.we; bus.dbg_addr = dbg_cur.addr; bus.dbg_wdata = dbg_cur.wdata;
    end else drive_side_random_payload(1'b1);

    if (model_idle(cyc) && (cpu_pend || dbg_pend)) begin
`ifdef HC4_ARB_ROUND_ROBIN_EN
      win_dbg = dbg_pend && (!cpu_pend || !last_dbg);
`else
      win_dbg = dbg_pend && !cpu_pend;
`endif
      last_dbg = win_dbg;
      t = win_dbg ? dbg_cur : cpu_cur;
      if (win_dbg) dbg_gr = 1; else cpu_gr = 1;
      g_cyc = cyc; g_dbg = win_dbg;
      g_we = t.we; g_addr = t.addr; g_wdata = t.wdata;
      if (t.we) ref_mem[t.addr] = t.wdata;
      else g_rd = ref_mem[t.addr];
    end
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (i > 0) check_zero();
      reset = 1'b1;
      bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
      drive_side_random_payload(1'b0);
      drive_side_random_payload(1'b1);
    end
    @(negedge clk);
    cyc++;
    check_zero();
    reset = 1'b0;
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    clear_model();
  endtask

  task automatic drain(int budget);
    int k = 0;
    while ((cpu_q.size() > 0 || dbg_q.size() > 0 || cpu_pend || dbg_pend || !model_idle(cyc))
           && k < budget) begin
      step();
      k++;
    end
    check_eq("drain_done", 32'(cpu_q.size() + dbg_q.size() + int'(cpu_pend) + int'(dbg_pend)), 0);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'd0; bus.cpu_wdata = 4'd0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 8'd0; bus.dbg_wdata = 4'd0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 4'($urandom_range(0, 15));
      ref_mem[i] = ram[i];
    end
    clear_model();
    nogap = 1;

    do_reset(3);

    // CPU write AB=5, then debug read-back
    cpu_q.push_back(mk_txn(1'b1, 8'hAB, 4'h5));
    drain(50);
    dbg_q.push_back(mk_txn(1'b0, 8'hAB, 4'h0));
    drain(50);
    check_eq("dbg_readback_AB", 32'(bus.dbg_rdata), 32'h5);

    // CPU read of 0A holding C
    ram[8'h0A] = 4'hC; ref_mem[8'h0A] = 4'hC;
    cpu_q.push_back(mk_txn(1'b0, 8'h0A, 4'h0));
    drain(50);
    check_eq("cpu_read_0A", 32'(bus.cpu_rdata), 32'hC);

    // Tie: both sides request 4 accesses starting together
    do_reset(2);
    ack_log.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_q.push_back(rnd_txn());
      dbg_q.push_back(rnd_txn());
    end
    drain(200);
    check_eq("tie_ack_count", 32'(ack_log.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < ack_log.size()) begin
`ifdef HC4_ARB_ROUND_ROBIN_EN
        check_eq("tie_order", 32'(ack_log[i]), 32'(i % 2));
`else
        check_eq("tie_order", 32'(ack_log[i]), 32'(i >= 4));
`endif
      end
    end

    // Reset during the second access cycle of a CPU read
    cpu_q.push_back(mk_txn(1'b0, 8'($urandom_range(0, 255)), 4'h0));
    k = 0;
    while (g_cyc < 0 && k < 10) begin step(); k++; end
    check_eq("midrst_granted", 32'(g_cyc >= 0), 1);
    step();
    ack_log.delete();
    do_reset(1);
    step();
    check_eq("midrst_no_ack", 32'(ack_log.size()), 0);
    cpu_q.push_back(mk_txn(1'b0, 8'h0A, 4'h0));
    drain(50);
    check_eq("midrst_fresh_ack", 32'(ack_log.size()), 1);
    check_eq("midrst_fresh_rdata", 32'(bus.cpu_rdata), 32'hC);

    // Randomized traffic
    nogap = 0;
    for (int i = 0; i < 2000; i++) begin
      if (cpu_q.size() < 2 && $urandom_range(0, 2) == 0) cpu_q.push_back(rnd_txn());
      if (dbg_q.size() < 2 && $urandom_range(0, 2) == 0) dbg_q.push_back(rnd_txn());
      step();
    end
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
